sonar_trigger: RTL
==================

# sonar_trigger

Trigger sequencer for the ultrasonic ranging front end. It issues the periodic trigger pulse to the ultrasonic sensor and supervises the returning echo window. It flags each completed or timed-out measurement and sits directly upstream of the echo pulse-width counter. The counter runs on the same `clk_1m` and samples the same `echo` pin; this block tells the rest of the design when the counter's result is fresh or when no echo arrived.

## Interface
Parameters:
- `TRIG_US`, 10: trigger high time, in `clk_1m` cycles (µs).
- `PERIOD_US`, 60000: trigger-rise to trigger-rise period.
- `ECHO_WAIT_US`, 30000: maximum wait from trigger fall to echo rise.
- `ECHO_MAX_US`, 25000: maximum echo high time.
- Constraint: `TRIG_US + ECHO_WAIT_US + ECHO_MAX_US < PERIOD_US`. All counters are 16 bits wide.

Ports:
- `clk_1m`  in  1  1 MHz system clock, the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable for periodic measurement.
- `echo`  in  1  raw sensor echo pin, asynchronous.
- `trig`  out  1  sensor trigger, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse: echo window closed normally.
- `timeout`  out  1  one-cycle pulse: echo missing or too long.
- `to_cnt`  out  8  consecutive-timeout count, saturating at 255.

## Operation
- `echo` passes through a 2-flop synchronizer. Edge detection compares sync stage 2 with a third flop.
- `cyc_cnt` counts cycles from trigger rise. `ph_cnt` counts cycles within the current phase and clears on every state change.
- FSM states and transitions:
  - IDLE: `trig`=0. If `en`=1, go to TRIG and clear `cyc_cnt`.
  - TRIG: `trig`=1. When `ph_cnt` = `TRIG_US`-1, go to WAIT_RISE.
  - WAIT_RISE: on a synced echo rise, go to WAIT_FALL. Otherwise, when `ph_cnt` = `ECHO_WAIT_US`-1, pulse `timeout` and go to HOLD.
  - WAIT_FALL: on a synced echo fall, pulse `done` and go to HOLD. Otherwise, when `ph_cnt` = `ECHO_MAX_US`-1, pulse `timeout` and go to HOLD.
  - HOLD: when `cyc_cnt` = `PERIOD_US`-1, go to TRIG (clearing `cyc_cnt`) if `en`=1, else go to IDLE.
- `en` is sampled only in IDLE and at HOLD exit. Deasserting `en` mid-cycle lets the current measurement finish.
- `to_cnt`:
  - +1 on each `timeout`, saturating at 255.
  - Cleared to 0 on `done`.
  - Unchanged when a cycle ends through IDLE.
- An echo edge seen in TRIG or HOLD is ignored. An echo already high at WAIT_RISE entry does not count as a rise.
- Only one of `done` and `timeout` is asserted in any cycle. If the echo fall coincides with the `ECHO_MAX_US` limit, `done` wins.
- Reset may arrive mid-operation. All state returns to IDLE asynchronously and `trig` drops immediately, with no partial pulse afterward.

## Timing
- Reset values: `trig`=0, `busy`=0, `done`=0, `timeout`=0, `to_cnt`=0. FSM is in IDLE and all counters are 0.
- Start latency: `en` high sampled at edge N gives `trig`=1 and `busy`=1 after edge N+1.
- `trig` is high for exactly `TRIG_US` cycles.
- Trigger rises in continuous operation are exactly `PERIOD_US` cycles apart.
- Echo edge to `done`: the `done` pulse occurs 3 cycles after the echo pin falls (2 synchronizer cycles plus 1 state-register cycle).
- Missing echo: `timeout` occurs `ECHO_WAIT_US` cycles after `trig` falls.
- Stuck-high echo: `timeout` occurs `ECHO_MAX_US` cycles after the synced echo rise.

## Configuration
- Macro: `SONAR_TIMEOUT_EN`.
- Defined:
  - The WAIT_RISE and WAIT_FALL limits are active as described above.
  - `timeout` and `to_cnt` are live.
- Undefined:
  - The limits are removed. WAIT_RISE waits indefinitely for a rise, and WAIT_FALL waits indefinitely for a fall.
  - `timeout` and `to_cnt` are tied to 0.
  - The period still holds whenever the echo completes before `PERIOD_US`. If the echo completes later, HOLD is entered late, `cyc_cnt` is past `PERIOD_US`-1, and the next trigger fires immediately at HOLD entry.

## Test plan
- Reset: assert `rst`=0 with `echo`=1 and `en`=1 → `trig`, `busy`, `done`, `timeout` all 0 and `to_cnt`=0. First `trig` appears 2 cycles after `rst` is released.
- Normal echo: `en`=1; echo rises 200 cycles after `trig` falls and stays high for 580 cycles → `trig` is high for exactly 10 cycles; one `done` pulse occurs 3 cycles after echo falls; no `timeout`; next `trig` rise is exactly 60000 cycles after the first.
- No echo: `en`=1 with `echo`=0 for 3 periods → 3 `timeout` pulses, each 30000 cycles after `trig` falls; `to_cnt`=3. A following normal echo gives `done` and `to_cnt`=0.
- Echo stuck high: echo rises 100 cycles after `trig` falls and stays high → `timeout` occurs 25000 cycles after the synced rise; `to_cnt`=1.
- Enable drop: deassert `en` during WAIT_FALL → `done` still pulses; FSM reaches IDLE at `cyc_cnt`=59999; `busy`=0; no further `trig`.
- Reset mid-trigger: pull `rst` low at the 5th `trig` cycle → `trig`=0 immediately, asynchronously, and the FSM is in IDLE.

Source files
------------

// File: rtl/sonar_trigger_if.sv
// Signal bundle between the ranging controller and sonar_trigger.
// The controller drives en/echo; the trigger sequencer drives the status outputs.
interface sonar_trigger_if;
  logic       en;
  logic       echo;
  logic       trig;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] to_cnt;

  modport master (
    output en, echo,
    input  trig, busy, done, timeout, to_cnt
  );

  modport slave (
    input  en, echo,
    output trig, busy, done, timeout, to_cnt
  );
endinterface

// File: rtl/sonar_trigger.sv
// Ultrasonic trigger sequencer: periodic trigger pulse plus echo-window supervision.
// Optional macro SONAR_TIMEOUT_EN enables echo wait/length limits, timeout and to_cnt.
module sonar_trigger #(
  parameter int TRIG_US      = 10,
  parameter int PERIOD_US    = 60000,
  parameter int ECHO_WAIT_US = 30000,
  parameter int ECHO_MAX_US  = 25000
) (
  input  logic           clk_1m,
  input  logic           rst,
  sonar_trigger_if.slave bus
);

  localparam logic [15:0] TRIG_LAST   = 16'(TRIG_US - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_US - 1);
`ifdef SONAR_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST   = 16'(ECHO_WAIT_US - 1);
  localparam logic [15:0] MAX_LAST    = 16'(ECHO_MAX_US - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] ph_q, ph_d;
  logic        echo_s1_q, echo_s2_q, echo_s3_q;
  logic        en_q;
  logic        trig_q;
  logic        done_q, done_d;
  logic        echo_rise, echo_fall;

  // Echo pin is asynchronous: two-flop synchronizer, third flop for edge detect.
  always_ff @(posedge clk_1m or negedge rst) begin
    if (!rst) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      echo_s1_q <= bus.echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
      en_q      <= bus.en;
    end
  end

  assign echo_rise =  echo_s2_q & ~echo_s3_q;
  assign echo_fall = ~echo_s2_q &  echo_s3_q;

`ifdef SONAR_TIMEOUT_EN
  logic       tmo_q, tmo_d;
  logic [7:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
`ifdef SONAR_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (en_q) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (ph_q == TRIG_LAST) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = S_WAIT_FALL;
`ifdef SONAR_TIMEOUT_EN
        end else if (ph_q == WAIT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_HOLD;
`endif
        end
      end
      S_WAIT_FALL: begin
        // A fall on the same cycle as the length limit counts as a good echo.
        if (echo_fall) begin
          done_d  = 1'b1;
          state_d = S_HOLD;
`ifdef SONAR_TIMEOUT_EN
        end else if (ph_q == MAX_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        // '>=' covers a late HOLD entry when the echo window has no limit.
        if (cyc_q >= PERIOD_LAST) state_d = en_q ? S_TRIG : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_d = cyc_q;
    if (state_d == S_TRIG && state_q != S_TRIG) begin
      cyc_d = '0;
    end else if (state_q != S_IDLE && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end

    ph_d = ph_q;
    if (state_d != state_q) begin
      ph_d = '0;
    end else if (ph_q != 16'hFFFF) begin
      ph_d = ph_q + 16'd1;
    end
  end

  always_ff @(posedge clk_1m or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      ph_q    <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ph_q    <= ph_d;
      trig_q  <= (state_d == S_TRIG);
      done_q  <= done_d;
    end
  end

`ifdef SONAR_TIMEOUT_EN
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (done_d) begin
      to_cnt_d = '0;
    end else if (tmo_d && to_cnt_q != 8'hFF) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_1m or negedge rst) begin
    if (!rst) begin
      tmo_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      tmo_q    <= tmo_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign bus.timeout = tmo_q;
  assign bus.to_cnt  = to_cnt_q;
`else
  assign bus.timeout = 1'b0;
  assign bus.to_cnt  = '0;
`endif

  assign bus.trig = trig_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;

endmodule
